// File: rtl/base_gfx_pkg.sv
// Shared types for the background graphics path: palette index, screen
// coordinate and the per-pixel sideband bundle carried alongside image data.
package base_gfx_pkg;

    typedef logic [7:0] index_t;
    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic blank;
        logic hs;
        logic vs;
        logic in_region;
    } sideband_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Idle sideband: blanked, syncs deasserted (high), outside the image.
    localparam sideband_t SB_IDLE = '{blank: 1'b0, hs: 1'b1, vs: 1'b1, in_region: 1'b0};

endpackage

// File: rtl/base_pixel_fetch_if.sv
// Video-timing, scroll-write, image-memory and palette-side signals of the
// background pixel fetch, bundled with producer (master) / fetch (slave) views.
interface base_pixel_fetch_if #(
    parameter int ADDR_W = 17
);
    import base_gfx_pkg::*;

    logic              pix_en;
    coord_t            DrawX;
    coord_t            DrawY;
    logic              blank_in;
    logic              hs_in;
    logic              vs_in;
    logic [1:0]        scroll_wr;
    logic [8:0]        scroll_wdata;
    logic [ADDR_W-1:0] rom_addr;
    index_t            rom_rddata;
    index_t            index;
    logic              blank_out;
    logic              hs_out;
    logic              vs_out;
    logic              scroll_pending;

    modport slave (
        input  pix_en, DrawX, DrawY, blank_in, hs_in, vs_in,
        input  scroll_wr, scroll_wdata, rom_rddata,
        output rom_addr, index, blank_out, hs_out, vs_out, scroll_pending
    );

    modport master (
        output pix_en, DrawX, DrawY, blank_in, hs_in, vs_in,
        output scroll_wr, scroll_wdata, rom_rddata,
        input  rom_addr, index, blank_out, hs_out, vs_out, scroll_pending
    );

endinterface

// File: rtl/base_sideband_delay.sv
// pix_en-gated shift register for sideband_t; every stage resets to idle so
// outputs stay blanked until fresh pixels have walked the full depth.
module base_sideband_delay
    import base_gfx_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_en,
    input  sideband_t i_d,
    output sideband_t o_q
);

    sideband_t r_stage [DEPTH];

    // NOTE: non-blocking assignments let every stage sample the previous
    // stage's old value on the same edge, which is what makes this a shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is a handful of flops, not a RAM, so resetting
            // every entry is cheap and guarantees clean sync after reset.
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= SB_IDLE;
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/base_pixel_fetch.sv
// Background pixel fetch: scrolled image address generation, frame-synchronous
// scroll commit, and sideband alignment across the image-memory read latency.
module base_pixel_fetch
    import base_gfx_pkg::*;
#(
    parameter int     IMG_W       = 320,
    parameter int     IMG_H       = 240,
    parameter int     SCALE_SHIFT = 1,
    parameter int     ROM_LAT     = 2,
    parameter index_t BG_INDEX    = 8'h00,
    parameter int     ADDR_W      = 17
) (
    input  logic                Clk,
    input  logic                Reset_n,
    base_pixel_fetch_if.slave   bus
);

    localparam int LAT = 1 + ROM_LAT;

    logic [10:0]       w_src_x, w_src_y;
    logic [10:0]       w_sum_x, w_sum_y;
    logic [10:0]       w_sx, w_sy;
    logic              w_in_region;
    logic [ADDR_W-1:0] w_addr;
    logic              w_wr_x, w_wr_y, w_commit;
    sideband_t         w_sb_in, w_sb_out;

    logic [8:0]        r_scroll_x_pend, r_scroll_y_pend;
    logic [8:0]        r_scroll_x_act, r_scroll_y_act;
    logic              r_scroll_pending;
    logic              r_vs_prev;
    logic [ADDR_W-1:0] r_rom_addr;

    // Constant-coefficient multiply by IMG_W, unrolled into shifted adds.
    function automatic logic [ADDR_W-1:0] mul_img_w(input logic [10:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            if (IMG_W[i]) acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    assign w_src_x = 11'(bus.DrawX) >> SCALE_SHIFT;
    assign w_src_y = 11'(bus.DrawY) >> SCALE_SHIFT;
    assign w_sum_x = w_src_x + 11'(r_scroll_x_act);
    assign w_sum_y = w_src_y + 11'(r_scroll_y_act);
    assign w_sx    = (w_sum_x >= 11'(IMG_W)) ? w_sum_x - 11'(IMG_W) : w_sum_x;
    assign w_sy    = (w_sum_y >= 11'(IMG_H)) ? w_sum_y - 11'(IMG_H) : w_sum_y;
    assign w_addr  = mul_img_w(w_sy) + ADDR_W'(w_sx);

    // Region test deliberately ignores scroll: it bounds the image on screen.
    assign w_in_region = (w_src_x < 11'(IMG_W)) && (w_src_y < 11'(IMG_H));

    assign w_wr_x   = bus.scroll_wr[0] && (bus.scroll_wdata < 9'(IMG_W));
    assign w_wr_y   = bus.scroll_wr[1] && (bus.scroll_wdata < 9'(IMG_H));
    assign w_commit = bus.pix_en && r_vs_prev && !bus.vs_in;

    // Commit copies the pre-write pending value; a coincident write stays pending.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_scroll_x_pend  <= '0;
            r_scroll_y_pend  <= '0;
            r_scroll_x_act   <= '0;
            r_scroll_y_act   <= '0;
            r_scroll_pending <= 1'b0;
            r_vs_prev        <= 1'b1;
        end else begin
            if (bus.pix_en) r_vs_prev <= bus.vs_in;
            if (w_commit) begin
                r_scroll_x_act <= r_scroll_x_pend;
                r_scroll_y_act <= r_scroll_y_pend;
            end
            if (w_wr_x) r_scroll_x_pend <= bus.scroll_wdata;
            if (w_wr_y) r_scroll_y_pend <= bus.scroll_wdata;
            if (w_wr_x || w_wr_y) r_scroll_pending <= 1'b1;
            else if (w_commit)    r_scroll_pending <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)        r_rom_addr <= '0;
        else if (bus.pix_en) r_rom_addr <= w_addr;
    end

    assign w_sb_in = '{blank: bus.blank_in, hs: bus.hs_in, vs: bus.vs_in, in_region: w_in_region};

    base_sideband_delay #(
        .DEPTH (LAT)
    ) u_sideband_delay (
        .clk   (Clk),
        .rst_n (Reset_n),
        .i_en  (bus.pix_en),
        .i_d   (w_sb_in),
        .o_q   (w_sb_out)
    );

    assign bus.rom_addr       = r_rom_addr;
    assign bus.index          = (w_sb_out.in_region && w_sb_out.blank) ? bus.rom_rddata : BG_INDEX;
    assign bus.blank_out      = w_sb_out.blank;
    assign bus.hs_out         = w_sb_out.hs;
    assign bus.vs_out         = w_sb_out.vs;
    assign bus.scroll_pending = r_scroll_pending;

endmodule
